stream_sink_checksum: RTL
=========================

STREAM_SINK_CHECKSUM -- requirements
Module: stream_sink_checksum

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 32, the stream payload width.
REQ-002 The block SHALL expose parameter CNT_W, default 64, the width of the element counter and of n.
REQ-003 The block SHALL have port ap_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port ap_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port ap_start, input, 1 bit: start request (ap_ctrl_hs).
REQ-006 The block SHALL have port ap_done, output, 1 bit: one-cycle completion pulse.
REQ-007 The block SHALL have port ap_idle, output, 1 bit: high while in IDLE.
REQ-008 The block SHALL have port ap_ready, output, 1 bit: one-cycle pulse, coincident with ap_done.
REQ-009 The block SHALL have port c_dout, input, DATA_W bits: upstream stream head payload.
REQ-010 The block SHALL have port c_dout_eot, input, 1 bit: the head token is a close (end-of-transfer) token.
REQ-011 The block SHALL have port c_empty_n, input, 1 bit: the head token is valid.
REQ-012 The block SHALL have port c_read, output, 1 bit: pops the head token in the same cycle.
REQ-013 The block SHALL have port n, input, CNT_W bits: expected element count, sampled at start.
REQ-014 The block SHALL have port count, output, CNT_W bits: number of data tokens consumed.
REQ-015 The block SHALL have port checksum, output, DATA_W bits: modulo-2^DATA_W sum of consumed payloads.
REQ-016 The block SHALL have port count_err, output, 1 bit: count differs from the latched n at completion.

Function
REQ-017 The FSM SHALL have states IDLE, READ and DONE; the reset state SHALL be IDLE.
REQ-018 In IDLE with ap_start=1, the block SHALL latch n, clear count, checksum and count_err, and move to READ on the next edge.
REQ-019 In READ, c_read SHALL equal c_empty_n combinationally; c_read SHALL be 0 in every other state.
REQ-020 A token SHALL be consumed in any cycle with c_read=1; the block SHALL never stall a valid token while in READ.
REQ-021 On a consumed token with c_dout_eot=0, count SHALL increment by 1 and checksum SHALL add c_dout, both wrapping, updated on the same edge.
REQ-022 On a consumed token with c_dout_eot=1, the block SHALL ignore the payload, leave count and checksum unchanged, and move to DONE.
REQ-023 In DONE, ap_done=1 and ap_ready=1 for exactly one cycle, count_err SHALL be registered as (count != latched n), and the next state SHALL be IDLE.
REQ-024 A token arriving in the first READ cycle SHALL be consumed in that cycle, so the latency from the start edge to the first c_read is 1 cycle.
REQ-025 ap_start held high through DONE SHALL trigger a new run only after the block re-enters IDLE; there SHALL be no back-to-back restart from DONE.
REQ-026 Tokens beyond n SHALL still be counted, and count_err SHALL be 1 at completion.
REQ-027 A close token as the first token SHALL complete the run with count=0 and checksum=0, and count_err=1 unless n=0.
REQ-028 count, checksum and count_err SHALL hold their values after DONE until the next accepted ap_start.
REQ-029 ap_start and n changes during READ or DONE SHALL be ignored.

Reset
REQ-030 When ap_rst=1 at an edge, the FSM SHALL go to IDLE and count, checksum, count_err and latched n SHALL clear to 0.
REQ-031 While ap_rst=1, ap_done=0, ap_ready=0 and c_read=0; ap_idle SHALL be 1 from the first edge after ap_rst is asserted.
REQ-032 Reset asserted mid-READ SHALL abort the run with no ap_done pulse and no further pops.

Verification
REQ-033 n=5, tokens 0x3F800000, 0x40400000, 0x40A00000, 0x40E00000, 0x41100000 then EOT -> count=5, checksum=0x42500000, count_err=0, exactly one ap_done pulse, 6 pops total.
REQ-034 c_empty_n toggling 1/0 every cycle over the same stream -> identical results, and c_read=0 in every empty cycle.
REQ-035 n=3 with the 5-token stream -> count=5, count_err=1; n=0 with EOT only -> count=0, checksum=0, count_err=0.
REQ-036 Tokens 0xFFFFFFFF and 0x00000002 then EOT -> checksum=0x00000001, confirming wrap.
REQ-037 ap_rst pulsed after 2 of 5 tokens -> outputs cleared, no ap_done, ap_idle=1; a restart then completes normally with count=5.
REQ-038 ap_start held high across two runs -> two separate ap_done pulses with at least one IDLE cycle between them.

Source files
------------

// File: rtl/stream_sink_checksum.sv
// Consumes a stream until the close token, then reports the element count, a wrapping payload sum and a length mismatch flag.
// The first pop comes 1 cycle after the start edge. In READ every valid head token is popped, so the sink never backpressures.
module stream_sink_checksum #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 64
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [DATA_W-1:0] c_dout,
  input  logic              c_dout_eot,
  input  logic              c_empty_n,
  output logic              c_read,
  input  logic [CNT_W-1:0]  n,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] checksum,
  output logic              count_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   n_lat;

  always_comb begin
    state_nxt = state;
    c_read    = 1'b0;
    ap_done   = 1'b0;
    ap_ready  = 1'b0;
    ap_idle   = (state == IDLE);
    case (state)
      IDLE: begin
        if (ap_start) state_nxt = READ;
      end
      READ: begin
        // Reset must silence the pop immediately, not one edge later.
        c_read = c_empty_n & ~ap_rst;
        if (c_empty_n && c_dout_eot) state_nxt = DONE;
      end
      DONE: begin
        ap_done   = ~ap_rst;
        ap_ready  = ~ap_rst;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state     <= IDLE;
      n_lat     <= '0;
      count     <= '0;
      checksum  <= '0;
      count_err <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (ap_start) begin
            n_lat     <= n;
            count     <= '0;
            checksum  <= '0;
            count_err <= 1'b0;
          end
        end
        READ: begin
          if (c_read && !c_dout_eot) begin
            count    <= count + CNT_W'(1);
            checksum <= checksum + c_dout;
          end
        end
        DONE: begin
          count_err <= (count != n_lat);
        end
        default: ;
      endcase
    end
  end

endmodule
